mcdt_formatter: RTL and testbench
=================================

MCDT_FORMATTER -- requirements
Module: mcdt_formatter

Interface
REQ-001 Parameter DEPTH, default 8, words per channel FIFO; power of two, 4..32.
REQ-002 Parameter DW, default 32, data width.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high; one clock, synchronous active-high reset is fixed.
REQ-005 mcdt_data_i  input  DW  word from the distributor output.
REQ-006 mcdt_val_i  input  1  word valid; no backpressure exists upstream.
REQ-007 mcdt_id_i  input  2  source channel 0..2.
REQ-008 fmt_len_i  input  2  packet length select: 0=1, 1=2, 2=4, 3=8 words.
REQ-009 fmt_grant_i  input  1  downstream grant of a pending request.
REQ-010 fmt_req_o  output  1  packet ready, request to send.
REQ-011 fmt_start_o  output  1  first word of packet.
REQ-012 fmt_end_o  output  1  last word of packet.
REQ-013 fmt_data_o  output  DW  packet word.
REQ-014 fmt_chid_o  output  2  channel of current packet.
REQ-015 fmt_length_o  output  4  word count of current packet.
REQ-016 fmt_ovf_o  output  3  sticky per-channel overflow flags.
REQ-017 fmt_iderr_o  output  1  sticky flag: word received with id 3.

Function
REQ-018 Words with mcdt_val_i=1 SHALL be written into the FIFO of channel mcdt_id_i in the same edge; FIFOs are independent.
REQ-019 Write to a full FIFO: word dropped, fmt_ovf_o[id] set, FIFO contents unchanged.
REQ-020 mcdt_id_i=3 with valid: word dropped, fmt_iderr_o set.
REQ-021 Simultaneous write and read of one FIFO: both occur; count unchanged; a full FIFO being read in that cycle accepts the write (no overflow).
REQ-022 FSM states IDLE, REQ, SEND, GAP.
REQ-023 IDLE: latch L = decoded fmt_len_i; if any channel count >= L, select channel by round-robin (priority starts after last-served channel, 0 after reset), latch fmt_chid_o and fmt_length_o=L, go REQ.
REQ-024 REQ: fmt_req_o=1, held until fmt_grant_i=1 sampled; then go SEND next cycle; chid/length/L stay frozen.
REQ-025 SEND: one word per cycle for exactly L cycles, fmt_start_o on first, fmt_end_o on last (both on the same cycle when L=1); data presented with zero-cycle lookahead from FIFO head.
REQ-026 fmt_grant_i is ignored outside REQ; fmt_len_i changes take effect only at next IDLE decision.
REQ-027 GAP: exactly one idle cycle after fmt_end_o, then IDLE; minimum packet spacing = L+3 cycles from request.
REQ-028 Outside SEND, fmt_start_o=fmt_end_o=0 and fmt_data_o=0.
REQ-029 Flags only clear on reset.

Reset
REQ-030 rst_i=1 at clock edge: FSM->IDLE, all FIFO pointers/counts 0, round-robin pointer 0, all outputs 0, flags cleared.
REQ-031 Reset mid-packet SHALL abort the packet; no fmt_end_o is generated; remaining data discarded.
REQ-032 Inputs sampled while rst_i=1 are ignored.

Structure
REQ-033 Shared package mcdt_fmt_pkg: FSM state enum, length-decode constants, channel-count constant 3.
REQ-034 One sub-module fmt_fifo (DEPTH x DW synchronous FIFO with count, full, empty), instantiated three times.

Verification
REQ-035 fmt_len_i=2, four words to ch1 (0x11..0x14) -> fmt_req_o, after grant four SEND cycles, data 0x11..0x14, chid 1, length 4, start/end on first/last.
REQ-036 DEPTH=8, nine back-to-back ch0 words, no grant -> fmt_ovf_o=3'b001, later packets deliver first eight words only.
REQ-037 Ch0 and ch2 both hold >=L words, grants immediate -> packets alternate 0,2,0,2; no channel served twice while other eligible.
REQ-038 fmt_len_i=0, single word 0xA5 on ch2 -> one-cycle packet with start=end=1, data 0xA5.
REQ-039 Assert rst_i in second SEND cycle of an 8-word packet -> next cycle all outputs 0, counts 0, no fmt_end_o.
REQ-040 mcdt_id_i=3 with valid -> fmt_iderr_o=1, no FIFO count changes.

Source files
------------

// File: rtl/mcdt_formatter_pkg.sv
// Shared types and constants for the MCDT packet formatter.
package mcdt_fmt_pkg;

  localparam int NUM_CH = 3;
  localparam logic [1:0] BAD_ID = 2'd3;

  localparam logic [3:0] LEN_SEL0 = 4'd1;
  localparam logic [3:0] LEN_SEL1 = 4'd2;
  localparam logic [3:0] LEN_SEL2 = 4'd4;
  localparam logic [3:0] LEN_SEL3 = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } fmt_state_e;

  function automatic logic [3:0] decode_len(input logic [1:0] sel);
    logic [3:0] len;
    case (sel)
      2'd0:    len = LEN_SEL0;
      2'd1:    len = LEN_SEL1;
      2'd2:    len = LEN_SEL2;
      default: len = LEN_SEL3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mcdt_formatter_if.sv
// Upstream word bus and downstream packet bus of the formatter.
interface mcdt_formatter_if #(parameter int DW = 32);

  logic [DW-1:0] mcdt_data_i;
  logic          mcdt_val_i;
  logic [1:0]    mcdt_id_i;
  logic          fmt_grant_i;
  logic          fmt_req_o;
  logic          fmt_start_o;
  logic          fmt_end_o;
  logic [DW-1:0] fmt_data_o;
  logic [1:0]    fmt_chid_o;
  logic [3:0]    fmt_length_o;

  modport master (
    output mcdt_data_i, mcdt_val_i, mcdt_id_i, fmt_grant_i,
    input  fmt_req_o, fmt_start_o, fmt_end_o, fmt_data_o, fmt_chid_o, fmt_length_o
  );

  modport slave (
    input  mcdt_data_i, mcdt_val_i, mcdt_id_i, fmt_grant_i,
    output fmt_req_o, fmt_start_o, fmt_end_o, fmt_data_o, fmt_chid_o, fmt_length_o
  );

endinterface

// File: rtl/mcdt_formatter_fifo.sv
// Per-channel synchronous FIFO; head word is visible combinationally.
// A full FIFO that is read in the same cycle still accepts the write.
module fmt_fifo
  import mcdt_fmt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_ok, rd_ok;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Accept/retire words and advance pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_ok    = rd_en_i && !empty_o;
    wr_ok    = wr_en_i && (!full_o || rd_ok);
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(wr_ok) - CW'(rd_ok);
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only slots below the count are ever read out.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mcdt_formatter.sv
// Collects words from three channels and emits fixed-length packets,
// choosing among ready channels round-robin.
//
// state | meaning
// IDLE  | wait until some channel holds L words, pick channel, latch L
// REQ   | fmt_req_o high until grant is sampled
// SEND  | one word per cycle for L cycles, start/end marked
// GAP   | one dead cycle before the next decision
module mcdt_formatter
  import mcdt_fmt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  fmt_len_i,
  output logic [2:0]  fmt_ovf_o,
  output logic        fmt_iderr_o,
  mcdt_formatter_if.slave bus
);

  fmt_state_e        state_q, state_d;
  logic [1:0]        chid_q, chid_d, rr_q, rr_d, pick;
  logic [3:0]        len_q, len_d, sent_q, sent_d, len_sel;
  logic [2:0]        ovf_q, ovf_d;
  logic              iderr_q, iderr_d, found;
  logic [NUM_CH-1:0] wr_en, rd_en, full, empty, elig, ovf;
  logic [DW-1:0]     head [NUM_CH];
  logic [CW-1:0]     ch_cnt [NUM_CH];
  logic [DW-1:0]     head_sel;

  assign len_sel = decode_len(fmt_len_i);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_en[c] = bus.mcdt_val_i && (bus.mcdt_id_i == 2'(c));
    assign elig[c]  = 8'(ch_cnt[c]) >= 8'(len_sel);
    assign ovf[c]   = wr_en[c] && full[c] && !rd_en[c];

    fmt_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (wr_en[c]),
      .wr_data_i (bus.mcdt_data_i),
      .rd_en_i   (rd_en[c]),
      .rd_data_o (head[c]),
      .count_o   (ch_cnt[c]),
      .full_o    (full[c]),
      .empty_o   (empty[c])
    );
  end

  assign bus.fmt_req_o    = (state_q == ST_REQ);
  assign bus.fmt_chid_o   = chid_q;
  assign bus.fmt_length_o = len_q;
  assign fmt_ovf_o        = ovf_q;
  assign fmt_iderr_o      = iderr_q;

  // Next state, round-robin pick, FIFO reads and packet outputs.
  always_comb begin
    state_d         = state_q;
    chid_d          = chid_q;
    len_d           = len_q;
    sent_d          = sent_q;
    rr_d            = rr_q;
    ovf_d           = ovf_q | ovf;
    iderr_d         = iderr_q | (bus.mcdt_val_i && (bus.mcdt_id_i == BAD_ID));
    rd_en           = '0;
    bus.fmt_start_o = 1'b0;
    bus.fmt_end_o   = 1'b0;
    bus.fmt_data_o  = '0;
    pick            = rr_q;
    found           = 1'b0;
    head_sel        = '0;

    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && elig[(int'(rr_q) + k) % NUM_CH]) begin
        found = 1'b1;
        pick  = 2'((int'(rr_q) + k) % NUM_CH);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (chid_q == 2'(c)) head_sel = head[c];
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          chid_d  = pick;
          len_d   = len_sel;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.fmt_grant_i) begin
          sent_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        for (int c = 0; c < NUM_CH; c++) begin
          rd_en[c] = (chid_q == 2'(c)) && !empty[c];
        end
        bus.fmt_start_o = (sent_q == 4'd0);
        bus.fmt_end_o   = (sent_q == len_q - 4'd1);
        bus.fmt_data_o  = head_sel;
        sent_d          = sent_q + 4'd1;
        if (bus.fmt_end_o) begin
          state_d = ST_GAP;
          rr_d    = (chid_q == 2'd2) ? 2'd0 : chid_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and sticky flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      chid_q  <= '0;
      len_q   <= '0;
      sent_q  <= '0;
      rr_q    <= '0;
      ovf_q   <= '0;
      iderr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chid_q  <= chid_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      iderr_q <= iderr_d;
    end
  end

endmodule

// File: tb/tb_mcdt_formatter.sv
// Directed bench for mcdt_formatter with hand-computed expectations.
module tb_mcdt_formatter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] fmt_len_i;
  logic [2:0] fmt_ovf_o;
  logic       fmt_iderr_o;
  int         n_checks = 0;
  int         n_fail   = 0;

  mcdt_formatter_if #(.DW(32)) bus();

  mcdt_formatter #(.DEPTH(8), .DW(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fmt_len_i   (fmt_len_i),
    .fmt_ovf_o   (fmt_ovf_o),
    .fmt_iderr_o (fmt_iderr_o),
    .bus         (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // A word is presented during reset; it must not land in any FIFO.
  task automatic apply_reset();
    rst_i = 1'b1;
    bus.mcdt_val_i  = 1'b1;
    bus.mcdt_id_i   = 2'd0;
    bus.mcdt_data_i = 32'hDEAD;
    bus.fmt_grant_i = 1'b1;
    tick();
    tick();
    bus.mcdt_val_i  = 1'b0;
    bus.fmt_grant_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] data);
    bus.mcdt_val_i  = 1'b1;
    bus.mcdt_id_i   = id;
    bus.mcdt_data_i = data;
    tick();
    bus.mcdt_val_i  = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int cyc = 0;
    while (!bus.fmt_req_o && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (bus.fmt_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_timeout: req=%b required 1 within 40 cycles", name, bus.fmt_req_o);
    end
  endtask

  task automatic recv_pkt(input string name, input logic [1:0] ch, input int len,
                          input logic [31:0] base);
    wait_req(name);
    n_checks++;
    if ({bus.fmt_chid_o, bus.fmt_length_o} !== {ch, 4'(len)}) begin
      n_fail++;
      $display("FAIL %s hdr: chid=%0d length=%0d required chid=%0d length=%0d",
               name, bus.fmt_chid_o, bus.fmt_length_o, ch, len);
    end
    bus.fmt_grant_i = 1'b1;
    tick();
    bus.fmt_grant_i = 1'b0;
    for (int i = 0; i < len; i++) begin
      n_checks++;
      if ({bus.fmt_start_o, bus.fmt_end_o, bus.fmt_data_o} !==
          {(i == 0), (i == len - 1), base + 32'(i)}) begin
        n_fail++;
        $display("FAIL %s word%0d: start=%b end=%b data=%h required start=%b end=%b data=%h",
                 name, i, bus.fmt_start_o, bus.fmt_end_o, bus.fmt_data_o,
                 (i == 0), (i == len - 1), base + 32'(i));
      end
      tick();
    end
    n_checks++;
    if ({bus.fmt_start_o, bus.fmt_end_o, bus.fmt_data_o, bus.fmt_req_o} !== 35'd0) begin
      n_fail++;
      $display("FAIL %s gap: start=%b end=%b data=%h req=%b required all 0",
               name, bus.fmt_start_o, bus.fmt_end_o, bus.fmt_data_o, bus.fmt_req_o);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.fmt_req_o, bus.fmt_start_o, bus.fmt_end_o, bus.fmt_data_o,
         bus.fmt_chid_o, bus.fmt_length_o, fmt_ovf_o, fmt_iderr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b start=%b end=%b data=%h chid=%0d len=%0d ovf=%b iderr=%b required all 0",
               bus.fmt_req_o, bus.fmt_start_o, bus.fmt_end_o, bus.fmt_data_o,
               bus.fmt_chid_o, bus.fmt_length_o, fmt_ovf_o, fmt_iderr_o);
    end
    n_checks++;
    if ({dut.ch_cnt[2], dut.ch_cnt[1], dut.ch_cnt[0]} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_counts: counts=%0d/%0d/%0d required 0/0/0",
               dut.ch_cnt[0], dut.ch_cnt[1], dut.ch_cnt[2]);
    end
  endtask

  task automatic test_basic_packet();
    fmt_len_i = 2'd2;
    for (int i = 0; i < 4; i++) push(2'd1, 32'h11 + 32'(i));
    wait_req("basic");
    tick();
    tick();
    tick();
    n_checks++;
    if (bus.fmt_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_req_held: req=%b required 1", bus.fmt_req_o);
    end
    recv_pkt("basic", 2'd1, 4, 32'h11);
  endtask

  task automatic test_single_word();
    fmt_len_i = 2'd0;
    push(2'd2, 32'hA5);
    recv_pkt("single", 2'd2, 1, 32'hA5);
  endtask

  task automatic test_bad_id();
    push(2'd3, 32'h33);
    n_checks++;
    if (fmt_iderr_o !== 1'b1) begin
      n_fail++;
      $display("FAIL iderr_flag: iderr=%b required 1", fmt_iderr_o);
    end
    n_checks++;
    if ({dut.ch_cnt[2], dut.ch_cnt[1], dut.ch_cnt[0]} !== 12'd0) begin
      n_fail++;
      $display("FAIL iderr_counts: counts=%0d/%0d/%0d required 0/0/0",
               dut.ch_cnt[0], dut.ch_cnt[1], dut.ch_cnt[2]);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    fmt_len_i = 2'd3;
    for (int i = 0; i < 9; i++) begin
      bus.mcdt_val_i  = 1'b1;
      bus.mcdt_id_i   = 2'd0;
      bus.mcdt_data_i = 32'h100 + 32'(i);
      tick();
    end
    bus.mcdt_val_i = 1'b0;
    n_checks++;
    if ({fmt_ovf_o, 4'(dut.ch_cnt[0])} !== {3'b001, 4'd8}) begin
      n_fail++;
      $display("FAIL ovf_flag: ovf=%b count0=%0d required ovf=001 count0=8",
               fmt_ovf_o, dut.ch_cnt[0]);
    end
    recv_pkt("ovf", 2'd0, 8, 32'h100);
    tick();
    tick();
    n_checks++;
    if ({fmt_ovf_o, 4'(dut.ch_cnt[0]), bus.fmt_req_o} !== {3'b001, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_after: ovf=%b count0=%0d req=%b required ovf=001 count0=0 req=0",
               fmt_ovf_o, dut.ch_cnt[0], bus.fmt_req_o);
    end
  endtask

  task automatic test_full_read_write();
    apply_reset();
    fmt_len_i = 2'd3;
    for (int i = 0; i < 8; i++) push(2'd2, 32'h80 + 32'(i));
    wait_req("fullrw");
    bus.fmt_grant_i = 1'b1;
    tick();
    bus.fmt_grant_i = 1'b0;
    push(2'd2, 32'h88);
    n_checks++;
    if ({fmt_ovf_o, 4'(dut.ch_cnt[2]), bus.fmt_data_o} !== {3'b000, 4'd8, 32'h81}) begin
      n_fail++;
      $display("FAIL fullrw_accept: ovf=%b count2=%0d data=%h required ovf=000 count2=8 data=81",
               fmt_ovf_o, dut.ch_cnt[2], bus.fmt_data_o);
    end
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if ({fmt_ovf_o, 4'(dut.ch_cnt[2])} !== {3'b000, 4'd1}) begin
      n_fail++;
      $display("FAIL fullrw_left: ovf=%b count2=%0d required ovf=000 count2=1",
               fmt_ovf_o, dut.ch_cnt[2]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fmt_len_i = 2'd3;
    for (int i = 0; i < 4; i++) push(2'd0, 32'h20 + 32'(i));
    for (int i = 0; i < 4; i++) push(2'd2, 32'h40 + 32'(i));
    fmt_len_i = 2'd1;
    recv_pkt("rr0", 2'd0, 2, 32'h20);
    recv_pkt("rr1", 2'd2, 2, 32'h40);
    recv_pkt("rr2", 2'd0, 2, 32'h22);
    recv_pkt("rr3", 2'd2, 2, 32'h42);
  endtask

  task automatic test_reset_mid_packet();
    logic saw_end = 1'b0;
    apply_reset();
    fmt_len_i = 2'd3;
    for (int i = 0; i < 8; i++) push(2'd1, 32'h60 + 32'(i));
    wait_req("abort");
    bus.fmt_grant_i = 1'b1;
    tick();
    bus.fmt_grant_i = 1'b0;
    tick();
    n_checks++;
    if ({bus.fmt_start_o, bus.fmt_data_o} !== {1'b0, 32'h61}) begin
      n_fail++;
      $display("FAIL abort_second_word: start=%b data=%h required start=0 data=61",
               bus.fmt_start_o, bus.fmt_data_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if ({bus.fmt_req_o, bus.fmt_start_o, bus.fmt_end_o, bus.fmt_data_o,
         bus.fmt_chid_o, bus.fmt_length_o, dut.ch_cnt[0], dut.ch_cnt[1], dut.ch_cnt[2]} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: req=%b start=%b end=%b data=%h chid=%0d len=%0d counts=%0d/%0d/%0d required all 0",
               bus.fmt_req_o, bus.fmt_start_o, bus.fmt_end_o, bus.fmt_data_o, bus.fmt_chid_o,
               bus.fmt_length_o, dut.ch_cnt[0], dut.ch_cnt[1], dut.ch_cnt[2]);
    end
    for (int i = 0; i < 12; i++) begin
      if (bus.fmt_end_o || bus.fmt_req_o) saw_end = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_end !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_end: end/req seen=%b required 0", saw_end);
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    fmt_len_i       = 2'd0;
    bus.mcdt_val_i  = 1'b0;
    bus.mcdt_id_i   = 2'd0;
    bus.mcdt_data_i = '0;
    bus.fmt_grant_i = 1'b0;
    test_reset();
    test_basic_packet();
    test_single_word();
    test_bad_id();
    test_overflow();
    test_full_read_write();
    test_back_to_back();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
